// File: rtl/instruction_loader.sv
// Byte-stream loader: validates SYNC/CHAN/LEN header, packs 2-byte words into the channel A/B instruction RAM write port.
// Optional LOADER_CHECKSUM_EN: trailing XOR checksum byte gates done; s_ready is always high after reset (never stalls).
module instruction_loader #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 17,
  parameter int MAX_WORDS  = 66584
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  wr_en_a,
  output logic                  wr_en_b,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHAN, S_LEN0, S_LEN1, S_LEN2, S_DLO, S_DHI, S_CSUM
  } state_t;

  state_t                r_state, w_next;
  logic                  r_ready;
  logic                  r_chan_b;
  logic [7:0]            r_len0, r_len1, r_lo;
  logic [ADDR_WIDTH-1:0] r_len, r_word_count, r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_en_a, r_wr_en_b, r_busy, r_done, r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic                  w_fire, w_sync, w_err, w_done, w_wr, w_last, w_len_bad;
  logic [23:0]           w_len24;
  logic [ADDR_WIDTH-1:0] w_wc_inc;

  assign w_fire    = s_valid && r_ready;
  assign w_len24   = {s_data, r_len1, r_len0};
  assign w_wc_inc  = r_word_count + 1'b1;
  assign w_last    = (w_wc_inc == r_len);
  assign w_len_bad = (w_len24 == 24'd0) || ({8'd0, w_len24} > 32'(MAX_WORDS)) ||
                     ((w_len24 >> ADDR_WIDTH) != 24'd0);

  always_comb begin
    w_next = r_state;
    w_sync = 1'b0;
    w_err  = 1'b0;
    w_done = 1'b0;
    w_wr   = 1'b0;
    if (w_fire) begin
      case (r_state)
        S_IDLE: if (s_data == 8'hA5) begin
          w_sync = 1'b1;
          w_next = S_CHAN;
        end
        S_CHAN: if (s_data == 8'h00 || s_data == 8'h01) begin
          w_next = S_LEN0;
        end else begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
        S_LEN0: w_next = S_LEN1;
        S_LEN1: w_next = S_LEN2;
        S_LEN2: if (w_len_bad) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_DLO;
        end
        S_DLO: w_next = S_DHI;
        S_DHI: begin
          w_wr = 1'b1;
          if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
            w_next = S_CSUM;
`else
            w_done = 1'b1;
            w_next = S_IDLE;
`endif
          end else begin
            w_next = S_DLO;
          end
        end
        S_CSUM: begin
          w_next = S_IDLE;
`ifdef LOADER_CHECKSUM_EN
          if (s_data == r_csum) w_done = 1'b1;
          else                  w_err  = 1'b1;
`endif
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_chan_b     <= 1'b0;
      r_len0       <= '0;
      r_len1       <= '0;
      r_lo         <= '0;
      r_len        <= '0;
      r_word_count <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_en_a    <= 1'b0;
      r_wr_en_b    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state   <= w_next;
      r_ready   <= 1'b1;
      r_wr_en_a <= w_wr && !r_chan_b;
      r_wr_en_b <= w_wr && r_chan_b;
      r_done    <= w_done;
      if (w_fire) begin
        case (r_state)
          S_CHAN:  r_chan_b <= s_data[0];
          S_LEN0:  r_len0   <= s_data;
          S_LEN1:  r_len1   <= s_data;
          S_LEN2:  r_len    <= w_len24[ADDR_WIDTH-1:0];
          S_DLO:   r_lo     <= s_data;
          default: ;
        endcase
      end
      if (w_wr) begin
        r_wr_addr    <= r_word_count;
        r_wr_data    <= {s_data[DATA_WIDTH-9:0], r_lo};
        r_word_count <= w_wc_inc;
      end
      if (w_sync) begin
        r_error      <= 1'b0;
        r_word_count <= '0;
        r_busy       <= 1'b1;
      end
      if (w_err) begin
        r_error <= 1'b1;
        r_busy  <= 1'b0;
      end
      if (w_done) r_busy <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      // Running XOR over everything between SYNC and the checksum byte itself.
      if (w_sync) r_csum <= '0;
      else if (w_fire && r_state != S_IDLE && r_state != S_CSUM) r_csum <= r_csum ^ s_data;
`endif
    end
  end

  assign s_ready    = r_ready;
  assign wr_en_a    = r_wr_en_a;
  assign wr_en_b    = r_wr_en_b;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed-frame bench for instruction_loader; expected RAM writes go into a scoreboard queue popped by a monitor.
// MAX_WORDS is reduced so the maximum-length frame fits a short run.
module tb_instruction_loader;
  localparam int DW     = 11;
  localparam int AW     = 17;
  localparam int TB_MAX = 40;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_ready, wr_en_a, wr_en_b, busy, done, error;
  logic [AW-1:0] wr_addr, word_count;
  logic [DW-1:0] wr_data;

  instruction_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WORDS(TB_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          chan;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] bq[$];
  int         sent = 0;
  int         checks = 0, failures = 0, done_cnt = 0, exp_done = 0;
  wr_t        mon_got, mon_want;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_en_a || wr_en_b) begin
      mon_got = {wr_en_b, wr_addr, wr_data};
      checks++;
      if (wr_en_a && wr_en_b) begin
        failures++;
        $display("FAIL both_strobes: addr 0x%0h data 0x%0h", wr_addr, wr_data);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: chanB=%0d addr 0x%0h data 0x%0h", wr_en_b, wr_addr, wr_data);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          failures++;
          $display("FAIL write: got chanB=%0d addr 0x%0h data 0x%0h expected chanB=%0d addr 0x%0h data 0x%0h",
                   mon_got.chan, mon_got.addr, mon_got.data, mon_want.chan, mon_want.addr, mon_want.data);
        end
      end
    end
  end

  task automatic new_frame();
    bq.delete();
    sent = 0;
  endtask

  task automatic send_pending();
    while (sent < bq.size()) begin
      s_data  = bq[sent];
      s_valid = 1'b1;
      sent++;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic add_word(input logic chan, input int addr, input logic [7:0] lo,
                          input logic [7:0] hi, input logic [DW-1:0] exp_data);
    bq.push_back(lo);
    bq.push_back(hi);
    exp_q.push_back({chan, AW'(addr), exp_data});
  endtask

  task automatic add_csum(input bit good);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = 8'h00;
    for (int i = 1; i < bq.size(); i++) c ^= bq[i];
    bq.push_back(good ? c : (c ^ 8'h01));
`else
    if (good) bq.delete(bq.size());
`endif
  endtask

  task automatic check_good_end(input string name, input int n);
    check({name, "_done"}, done, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_error"}, error, 0);
    check({name, "_wcount"}, word_count, n);
    exp_done++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("s_ready_rise", s_ready, 1);
  endtask

  initial begin
    logic [23:0] bad_len [4];
    logic [10:0] d;
    bad_len = '{24'd0, 24'd66585, 24'h020000, 24'(TB_MAX + 1)};

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_wr_en_a", wr_en_a, 0);
    check("rst_wr_en_b", wr_en_b, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_wcount", word_count, 0);
    release_reset();

    // Basic channel A frame
    new_frame();
    bq.push_back(8'hA5); bq.push_back(8'h00); bq.push_back(8'h02); bq.push_back(8'h00); bq.push_back(8'h00);
    send_pending();
    check("f1_busy", busy, 1);
    check("f1_wcount0", word_count, 0);
    add_word(1'b0, 0, 8'h34, 8'h12, 11'h234);
    send_pending();
    check("f1_wr_latency", wr_en_a, 1);
    add_word(1'b0, 1, 8'hFF, 8'h07, 11'h7FF);
    add_csum(1);
    send_pending();
    check_good_end("f1", 2);
    @(posedge clk); #1;
    check("f1_done_pulse", done, 0);
    check("f1_wcount_hold", word_count, 2);

    // Garbage then channel B frame
    new_frame();
    bq.push_back(8'h00); bq.push_back(8'h13); bq.push_back(8'hFF);
    send_pending();
    check("garbage_busy", busy, 0);
    new_frame();
    bq.push_back(8'hA5); bq.push_back(8'h01); bq.push_back(8'h01); bq.push_back(8'h00); bq.push_back(8'h00);
    add_word(1'b1, 0, 8'hAA, 8'h05, 11'h5AA);
    add_csum(1);
    send_pending();
    check_good_end("f2", 1);

    // Bad channel, then recovery on next SYNC
    new_frame();
    bq.push_back(8'hA5); bq.push_back(8'h02);
    send_pending();
    check("badchan_error", error, 1);
    check("badchan_busy", busy, 0);
    new_frame();
    bq.push_back(8'hA5);
    send_pending();
    check("resync_error_clr", error, 0);
    check("resync_busy", busy, 1);
    check("resync_wcount", word_count, 0);
    bq.push_back(8'h00); bq.push_back(8'h01); bq.push_back(8'h00); bq.push_back(8'h00);
    add_word(1'b0, 0, 8'h11, 8'h22, 11'h211);
    add_csum(1);
    send_pending();
    check_good_end("f3", 1);

    // Illegal lengths: no writes, error, trailing bytes ignored
    for (int k = 0; k < 4; k++) begin
      new_frame();
      bq.push_back(8'hA5); bq.push_back(8'h00);
      bq.push_back(bad_len[k][7:0]); bq.push_back(bad_len[k][15:8]); bq.push_back(bad_len[k][23:16]);
      send_pending();
      check($sformatf("len_err_%0d", k), error, 1);
      check($sformatf("len_busy_%0d", k), busy, 0);
      new_frame();
      bq.push_back(8'h11); bq.push_back(8'h22);
      send_pending();
    end

    // Maximum-length frame; HI bytes carry junk above the word width
    new_frame();
    bq.push_back(8'hA5); bq.push_back(8'h00); bq.push_back(8'(TB_MAX)); bq.push_back(8'h00); bq.push_back(8'h00);
    for (int i = 0; i < TB_MAX; i++) begin
      d = 11'((i * 37 + 5) & 32'h7FF);
      add_word(1'b0, i, d[7:0], {5'b11111, d[10:8]}, d);
    end
    add_csum(1);
    send_pending();
    check_good_end("fmax", TB_MAX);
    check("fmax_last_addr", wr_addr, TB_MAX - 1);

`ifdef LOADER_CHECKSUM_EN
    new_frame();
    bq.push_back(8'hA5); bq.push_back(8'h01); bq.push_back(8'h01); bq.push_back(8'h00); bq.push_back(8'h00);
    add_word(1'b1, 0, 8'h44, 8'h03, 11'h344);
    add_csum(0);
    send_pending();
    check("badcsum_error", error, 1);
    check("badcsum_done", done, 0);
    check("badcsum_busy", busy, 0);
    check("badcsum_wcount", word_count, 1);
`endif

    // Reset while the HI byte of word 3 is on the bus
    new_frame();
    bq.push_back(8'hA5); bq.push_back(8'h00); bq.push_back(8'h0A); bq.push_back(8'h00); bq.push_back(8'h00);
    add_word(1'b0, 0, 8'h01, 8'h00, 11'h001);
    add_word(1'b0, 1, 8'h02, 8'h00, 11'h002);
    bq.push_back(8'h99);
    send_pending();
    s_data  = 8'h01;
    s_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_s_ready", s_ready, 0);
    check("midrst_wr_en_a", wr_en_a, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_wcount", word_count, 0);
    check("midrst_error", error, 0);
    @(posedge clk); #1;
    check("midrst_no_strobe", wr_en_a, 0);
    s_valid = 1'b0;
    release_reset();
    new_frame();
    bq.push_back(8'hA5); bq.push_back(8'h01); bq.push_back(8'h03); bq.push_back(8'h00); bq.push_back(8'h00);
    add_word(1'b1, 0, 8'h10, 8'h01, 11'h110);
    add_word(1'b1, 1, 8'h20, 8'h02, 11'h220);
    add_word(1'b1, 2, 8'h30, 8'h03, 11'h330);
    add_csum(1);
    send_pending();
    check_good_end("fpost", 3);
    check("fpost_last_addr", wr_addr, 2);

    repeat (4) @(posedge clk);
    #1;
    check("pending_writes", exp_q.size(), 0);
    check("done_pulses", done_cnt, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
